// File: rtl/cache_port_arbiter_pkg.sv
// Shared types and constants for the cache port arbiter and its neighbours.
// Default widths match a 64-bit PC split into line address and word select.
package cache_port_arbiter_pkg;

    localparam int DEF_LINE_W       = 58;
    localparam int DEF_WSEL_W       = 4;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_STARVE_LIMIT = 4;

    localparam logic [31:0] NOP_INST = 32'h0100_0000;

    typedef enum logic [1:0] {
        IDLE,
        GNT_I,
        GNT_D,
        REL
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

    typedef struct packed {
        logic                  we;
        logic [DEF_LINE_W-1:0] line_addr;
        logic [DEF_WSEL_W-1:0] word_select;
        logic [DEF_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/cache_port_arbiter_if.sv
// Bundles the fetch port, the data port and the shared cache port.
// The master modport is the arbiter's view; slave is the surrounding stages plus the cache.
interface cache_port_arbiter_if
    import cache_port_arbiter_pkg::*;
#(
    parameter int LINE_W = DEF_LINE_W,
    parameter int WSEL_W = DEF_WSEL_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic              i_req;
    logic [LINE_W-1:0] i_line_addr;
    logic [WSEL_W-1:0] i_word_select;
    logic              i_ack;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [LINE_W-1:0] d_line_addr;
    logic [WSEL_W-1:0] d_word_select;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    logic              m_req;
    logic              m_we;
    logic [LINE_W-1:0] m_line_addr;
    logic [WSEL_W-1:0] m_word_select;
    logic [DATA_W-1:0] m_wdata;
    logic              m_ack;
    logic [DATA_W-1:0] m_rdata;

    modport master (
        input  i_req, i_line_addr, i_word_select,
        input  d_req, d_we, d_line_addr, d_word_select, d_wdata,
        input  m_ack, m_rdata,
        output i_ack, i_rdata,
        output d_ack, d_rdata,
        output m_req, m_we, m_line_addr, m_word_select, m_wdata
    );

    modport slave (
        output i_req, i_line_addr, i_word_select,
        output d_req, d_we, d_line_addr, d_word_select, d_wdata,
        output m_ack, m_rdata,
        input  i_ack, i_rdata,
        input  d_ack, d_rdata,
        input  m_req, m_we, m_line_addr, m_word_select, m_wdata
    );

endinterface

// File: rtl/cache_port_arbiter_sat_counter.sv
// Small saturating up-counter with synchronous clear; reports when it sits at LIMIT.
// Used here to count consecutive D-grants that left the fetch port waiting.
module cache_port_arbiter_sat_counter #(
    parameter int LIMIT = 4,
    parameter int W     = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic saturated
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && !saturated) begin
            count <= count + 1'b1;
        end
    end

    assign saturated = (count == W'(LIMIT));

endmodule

// File: rtl/cache_port_arbiter.sv
// Arbitrates the single cache port between instruction fetch and the memory stage.
// Data side has priority until the fetch side has been passed over STARVE_LIMIT times in a row.
module cache_port_arbiter
    import cache_port_arbiter_pkg::*;
#(
    parameter int LINE_W       = DEF_LINE_W,
    parameter int WSEL_W       = DEF_WSEL_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                  clk,
    input  logic                  reset,
    cache_port_arbiter_if.master  bus,
    output logic                  busy,
    output owner_t                last_owner
);

    typedef struct packed {
        logic              we;
        logic [LINE_W-1:0] line_addr;
        logic [WSEL_W-1:0] word_select;
        logic [DATA_W-1:0] wdata;
    } req_t;

    arb_state_t state, state_nx;
    logic       m_req, m_req_nx;
    req_t       req, req_nx;
    owner_t     last_owner_nx;
    logic       starve_inc, starve_clr, starve_sat;
    logic       d_wins;

    // Once the fetch side has been skipped enough times, it wins a tie.
    assign d_wins = bus.d_req && (!bus.i_req || !starve_sat);

    always_comb begin
        state_nx      = state;
        m_req_nx      = m_req;
        req_nx        = req;
        last_owner_nx = last_owner;
        starve_inc    = 1'b0;
        starve_clr    = 1'b0;

        case (state)
            IDLE: begin
                if (d_wins) begin
                    state_nx           = GNT_D;
                    m_req_nx           = 1'b1;
                    req_nx.we          = bus.d_we;
                    req_nx.line_addr   = bus.d_line_addr;
                    req_nx.word_select = bus.d_word_select;
                    req_nx.wdata       = bus.d_wdata;
                end else if (bus.i_req) begin
                    state_nx           = GNT_I;
                    m_req_nx           = 1'b1;
                    req_nx.we          = 1'b0;
                    req_nx.line_addr   = bus.i_line_addr;
                    req_nx.word_select = bus.i_word_select;
                    req_nx.wdata       = '0;
                end
            end

            GNT_I: begin
                if (bus.m_ack) begin
                    state_nx      = REL;
                    m_req_nx      = 1'b0;
                    last_owner_nx = OWN_I;
                    starve_clr    = 1'b1;
                end
            end

            GNT_D: begin
                if (bus.m_ack) begin
                    state_nx      = REL;
                    m_req_nx      = 1'b0;
                    last_owner_nx = OWN_D;
                    starve_inc    = bus.i_req;
                end
            end

            REL: begin
                state_nx = IDLE;
            end

            default: begin
                state_nx = IDLE;
                m_req_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            m_req      <= 1'b0;
            req        <= '0;
            last_owner <= OWN_I;
        end else begin
            state      <= state_nx;
            m_req      <= m_req_nx;
            req        <= req_nx;
            last_owner <= last_owner_nx;
        end
    end

    cache_port_arbiter_sat_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk       (clk),
        .reset     (reset),
        .clear     (starve_clr),
        .inc       (starve_inc),
        .saturated (starve_sat)
    );

    assign bus.m_req         = m_req;
    assign bus.m_we          = req.we;
    assign bus.m_line_addr   = req.line_addr;
    assign bus.m_word_select = req.word_select;
    assign bus.m_wdata       = req.wdata;

    // Acks pass straight through to whichever side currently owns the port.
    assign bus.i_ack   = (state == GNT_I) && bus.m_ack;
    assign bus.i_rdata = (state == GNT_I) ? bus.m_rdata : '0;
    assign bus.d_ack   = (state == GNT_D) && bus.m_ack;
    assign bus.d_rdata = (state == GNT_D) ? bus.m_rdata : '0;

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed and randomized checks of cache_port_arbiter against a transaction-level model.
// The model tracks one in-flight transfer plus a one-cycle cooldown after each ack.
module tb_cache_port_arbiter;
    import cache_port_arbiter_pkg::*;

    localparam int LINE_W = DEF_LINE_W;
    localparam int WSEL_W = DEF_WSEL_W;
    localparam int DATA_W = DEF_DATA_W;
    localparam int LIMIT  = DEF_STARVE_LIMIT;

    logic   clk = 1'b0;
    logic   reset;
    logic   busy;
    owner_t last_owner;

    always #5 clk = ~clk;

    cache_port_arbiter_if #(.LINE_W(LINE_W), .WSEL_W(WSEL_W), .DATA_W(DATA_W)) bus ();

    cache_port_arbiter #(
        .LINE_W(LINE_W), .WSEL_W(WSEL_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .busy       (busy),
        .last_owner (last_owner)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: one transfer in flight, a cooldown cycle, a count of skipped fetches.
    bit              xfer_active = 0;
    bit              xfer_from_d = 0;
    bit              cooldown    = 0;
    bit              fresh_reset = 1;
    int              skipped_i   = 0;
    bit              prev_was_d  = 0;
    logic              xfer_we    = 1'b0;
    logic [LINE_W-1:0] xfer_addr  = '0;
    logic [WSEL_W-1:0] xfer_wsel  = '0;
    logic [DATA_W-1:0] xfer_wdata = '0;

    bit seen_i_ack, seen_d_ack;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_advance();
        if (!reset) begin
            xfer_active = 0; cooldown = 0; fresh_reset = 1; skipped_i = 0; prev_was_d = 0;
            xfer_we = 1'b0; xfer_addr = '0; xfer_wsel = '0; xfer_wdata = '0;
        end else if (cooldown) begin
            cooldown = 0;
        end else if (xfer_active) begin
            if (bus.m_ack) begin
                xfer_active = 0;
                cooldown    = 1;
                fresh_reset = 0;
                prev_was_d  = xfer_from_d;
                if (xfer_from_d) begin
                    if (bus.i_req && skipped_i < LIMIT) skipped_i = skipped_i + 1;
                end else begin
                    skipped_i = 0;
                end
            end
        end else if (bus.d_req && (!bus.i_req || skipped_i < LIMIT)) begin
            xfer_active = 1; xfer_from_d = 1; fresh_reset = 0;
            xfer_we = bus.d_we; xfer_addr = bus.d_line_addr;
            xfer_wsel = bus.d_word_select; xfer_wdata = bus.d_wdata;
        end else if (bus.i_req) begin
            xfer_active = 1; xfer_from_d = 0; fresh_reset = 0;
            xfer_we = 1'b0; xfer_addr = bus.i_line_addr;
            xfer_wsel = bus.i_word_select; xfer_wdata = '0;
        end
    endtask

    task automatic settle();
        bit e_i_ack, e_d_ack;
        @(negedge clk);
        e_i_ack = xfer_active && !xfer_from_d && bus.m_ack;
        e_d_ack = xfer_active &&  xfer_from_d && bus.m_ack;
        check_output("m_req", 64'(bus.m_req), 64'(xfer_active));
        check_output("busy", 64'(busy), 64'(xfer_active || cooldown));
        check_output("i_ack", 64'(bus.i_ack), 64'(e_i_ack));
        check_output("d_ack", 64'(bus.d_ack), 64'(e_d_ack));
        check_output("i_rdata", 64'(bus.i_rdata), (xfer_active && !xfer_from_d) ? 64'(bus.m_rdata) : 64'h0);
        check_output("d_rdata", 64'(bus.d_rdata), (xfer_active &&  xfer_from_d) ? 64'(bus.m_rdata) : 64'h0);
        check_output("last_owner", 64'(last_owner), 64'(prev_was_d));
        if (xfer_active || fresh_reset) begin
            check_output("m_we", 64'(bus.m_we), 64'(xfer_we));
            check_output("m_line_addr", 64'(bus.m_line_addr), 64'(xfer_addr));
            check_output("m_word_select", 64'(bus.m_word_select), 64'(xfer_wsel));
            check_output("m_wdata", 64'(bus.m_wdata), 64'(xfer_wdata));
        end
        seen_i_ack = e_i_ack;
        seen_d_ack = e_d_ack;
    endtask

    task automatic tick();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic apply_stimulus(input int n);
        for (int k = 0; k < n; k++) begin
            settle();
            tick();
        end
    endtask

    task automatic clear_inputs();
        bus.i_req = 0; bus.i_line_addr = '0; bus.i_word_select = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_line_addr = '0; bus.d_word_select = '0; bus.d_wdata = '0;
        bus.m_ack = 0; bus.m_rdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_inputs();
        apply_stimulus(2);
        reset = 1'b1;
    endtask

    initial begin
        logic [5:0] order;
        int n_grants, n_acks, first_ack, last_ack;

        do_reset();
        $display("[TB] fetch-only read with a two-cycle cache");
        bus.i_req = 1; bus.i_line_addr = LINE_W'(8'h10); bus.i_word_select = 4'd3;
        apply_stimulus(1);
        settle();
        check_output("t1_m_req", 64'(bus.m_req), 64'h1);
        check_output("t1_addr", 64'(bus.m_line_addr), 64'h10);
        check_output("t1_wsel", 64'(bus.m_word_select), 64'h3);
        check_output("t1_we", 64'(bus.m_we), 64'h0);
        tick();
        apply_stimulus(1);
        bus.m_ack = 1; bus.m_rdata = 32'hDEAD_BEEF;
        settle();
        check_output("t1_i_ack", 64'(bus.i_ack), 64'h1);
        check_output("t1_i_rdata", 64'(bus.i_rdata), 64'hDEAD_BEEF);
        tick();
        bus.m_ack = 0; bus.i_req = 0;
        settle();
        check_output("t1_rel_busy", 64'(busy), 64'h1);
        check_output("t1_rel_ack", 64'(bus.i_ack), 64'h0);
        check_output("t1_rel_m_req", 64'(bus.m_req), 64'h0);
        tick();
        settle();
        check_output("t1_idle_busy", 64'(busy), 64'h0);
        tick();

        $display("[TB] both ports requesting, zero-wait cache");
        do_reset();
        bus.i_req = 1; bus.i_line_addr = LINE_W'(12'h100); bus.i_word_select = 4'd1;
        bus.d_req = 1; bus.d_line_addr = LINE_W'(12'h200); bus.d_word_select = 4'd2;
        bus.m_ack = 1; bus.m_rdata = 32'h0000_1111;
        order = '0; n_grants = 0;
        for (int c = 0; c < 18; c++) begin
            settle();
            if (bus.i_ack || bus.d_ack) begin
                order = {order[4:0], bus.d_ack};
                n_grants++;
            end
            tick();
        end
        check_output("t2_grants", 64'(n_grants), 64'd6);
        check_output("t2_order", 64'(order), 64'b111101);

        $display("[TB] data write with early request drop");
        do_reset();
        bus.d_req = 1; bus.d_we = 1; bus.d_line_addr = LINE_W'(12'h3FF);
        bus.d_word_select = 4'd5; bus.d_wdata = 32'h1234_5678;
        apply_stimulus(1);
        settle();
        check_output("t3_m_we", 64'(bus.m_we), 64'h1);
        check_output("t3_addr", 64'(bus.m_line_addr), 64'h3FF);
        check_output("t3_wdata", 64'(bus.m_wdata), 64'h1234_5678);
        tick();
        bus.d_req = 0; bus.d_wdata = 32'hFFFF_0000; bus.d_line_addr = '0;
        apply_stimulus(1);
        settle();
        check_output("t3_held_req", 64'(bus.m_req), 64'h1);
        check_output("t3_held_wdata", 64'(bus.m_wdata), 64'h1234_5678);
        tick();
        bus.m_ack = 1; bus.m_rdata = 32'h0000_0055;
        settle();
        check_output("t3_d_ack", 64'(bus.d_ack), 64'h1);
        tick();
        bus.m_ack = 0;
        apply_stimulus(2);

        $display("[TB] stray cache acks in idle and release");
        bus.m_ack = 1;
        settle();
        check_output("t4_idle_i_ack", 64'(bus.i_ack), 64'h0);
        check_output("t4_idle_d_ack", 64'(bus.d_ack), 64'h0);
        check_output("t4_idle_busy", 64'(busy), 64'h0);
        tick();
        bus.m_ack = 0; bus.i_req = 1; bus.i_line_addr = LINE_W'(8'h20);
        apply_stimulus(1);
        bus.m_ack = 1;
        settle();
        check_output("t4_i_ack", 64'(bus.i_ack), 64'h1);
        tick();
        bus.i_req = 0;
        settle();
        check_output("t4_rel_i_ack", 64'(bus.i_ack), 64'h0);
        check_output("t4_rel_busy", 64'(busy), 64'h1);
        tick();
        settle();
        check_output("t4_after_busy", 64'(busy), 64'h0);
        tick();
        bus.m_ack = 0;

        $display("[TB] reset during a data grant");
        bus.d_req = 1; bus.d_we = 0; bus.d_line_addr = LINE_W'(8'h40);
        apply_stimulus(1);
        reset = 1'b0; bus.d_req = 0;
        settle();
        check_output("t5_pre_m_req", 64'(bus.m_req), 64'h1);
        tick();
        reset = 1'b1;
        settle();
        check_output("t5_m_req", 64'(bus.m_req), 64'h0);
        check_output("t5_busy", 64'(busy), 64'h0);
        check_output("t5_d_ack", 64'(bus.d_ack), 64'h0);
        tick();
        bus.i_req = 1; bus.i_line_addr = LINE_W'(8'h80); bus.i_word_select = 4'd7;
        apply_stimulus(1);
        bus.m_ack = 1; bus.m_rdata = 32'hCAFE_F00D;
        settle();
        check_output("t5_i_ack", 64'(bus.i_ack), 64'h1);
        check_output("t5_i_rdata", 64'(bus.i_rdata), 64'hCAFE_F00D);
        tick();
        bus.i_req = 0; bus.m_ack = 0;
        apply_stimulus(2);

        $display("[TB] back-to-back fetches, zero-wait cache");
        do_reset();
        bus.i_req = 1; bus.i_line_addr = LINE_W'(8'h44);
        bus.m_ack = 1; bus.m_rdata = 32'h0BAD_CAFE;
        n_acks = 0; first_ack = -1; last_ack = -1;
        for (int c = 0; c < 12; c++) begin
            settle();
            if (bus.i_ack) begin
                n_acks++;
                if (first_ack < 0) first_ack = c;
                last_ack = c;
            end
            tick();
        end
        check_output("t6_acks", 64'(n_acks), 64'd4);
        check_output("t6_first", 64'(first_ack), 64'd1);
        check_output("t6_last", 64'(last_ack), 64'd10);

        $display("[TB] randomized traffic");
        do_reset();
        for (int c = 0; c < 600; c++) begin
            settle();
            tick();
            reset = ($urandom_range(0, 49) != 0);
            if (bus.i_req) begin
                if (seen_i_ack) begin
                    bus.i_req = ($urandom_range(0, 1) == 1);
                    bus.i_line_addr = LINE_W'({$urandom(), $urandom()});
                    bus.i_word_select = WSEL_W'($urandom());
                end
            end else if ($urandom_range(0, 3) == 0) begin
                bus.i_req = 1;
                bus.i_line_addr = LINE_W'({$urandom(), $urandom()});
                bus.i_word_select = WSEL_W'($urandom());
            end
            if (bus.d_req) begin
                if (seen_d_ack) begin
                    bus.d_req = ($urandom_range(0, 1) == 1);
                    bus.d_we = $urandom_range(0, 1) == 1;
                    bus.d_line_addr = LINE_W'({$urandom(), $urandom()});
                    bus.d_word_select = WSEL_W'($urandom());
                    bus.d_wdata = $urandom();
                end
            end else if ($urandom_range(0, 2) == 0) begin
                bus.d_req = 1;
                bus.d_we = $urandom_range(0, 1) == 1;
                bus.d_line_addr = LINE_W'({$urandom(), $urandom()});
                bus.d_word_select = WSEL_W'($urandom());
                bus.d_wdata = $urandom();
            end
            bus.m_ack = ($urandom_range(0, 2) == 0);
            bus.m_rdata = $urandom();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
